// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes,
// FSM state encoding and request classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  // Unsigned variants only make sense for loads, so any 1xx code on a store is illegal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = we & f3[2];
    endcase
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response channel from the execute stage and the word-wide data-memory
// channel driven by the load/store unit.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into a read word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'b0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'b0, shifted[15:0]};
      F3_W:    rdata_ext = word;
      default: rdata_ext = '0;
    endcase
  end

  // A halfword store occupies the lane pair selected by offset[1]; its upper
  // byte lands in the odd lane of that pair.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_src;

      assign lane_hit = ((funct3 == F3_B) && (offset == LANE)) ||
                        ((funct3 == F3_H) && (offset[1] == LANE[1]));
      assign lane_src = ((funct3 == F3_H) && LANE[0]) ? wdata[15:8] : wdata[7:0];
      assign merged[8*gi +: 8] = lane_hit ? lane_src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: turns one RV32I byte/half/word request at a time into word
// accesses on a byte-enable-less data memory, using read-modify-write for sub-word stores.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  offset_q, offset_d;
  logic [15:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d;
  logic        resp_fault_q, resp_fault_d;
  logic        mem_r_q, mem_r_d;
  logic        mem_w_q, mem_w_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        acc_fault;
  logic        acc_mis;
  logic [31:0] rdata_ext;
  logic [31:0] merged;

  lsu_align u_align (
    .offset    (offset_q),
    .funct3    (f3_q),
    .word      (mem.mem_rdata),
    .wdata     (wdata_q),
    .rdata_ext (rdata_ext),
    .merged    (merged)
  );

  assign acc_fault = f3_illegal(req.req_we, req.req_funct3) ||
                     (req.req_addr[31:2] >= WORD_LIMIT);
  assign acc_mis   = is_misaligned(req.req_funct3, req.req_addr[1:0]);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    resp_fault_d = resp_fault_q;
    mem_r_d      = 1'b0;
    mem_w_d      = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req.req_valid) begin
          req_ready_d = 1'b0;
          we_d        = req.req_we;
          f3_d        = req.req_funct3;
          offset_d    = req.req_addr[1:0];
          wdata_d     = req.req_wdata[15:0];
          if (acc_fault || acc_mis) begin
            // Rejected requests never touch memory; fault outranks misalignment.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_fault_d = acc_fault;
            resp_mis_d   = ~acc_fault;
          end else if (!req.req_we || (req.req_funct3 != F3_W)) begin
            state_d    = ST_RD;
            mem_r_d    = 1'b1;
            mem_addr_d = {req.req_addr[31:2], 2'b00};
          end else begin
            state_d     = ST_WR;
            mem_w_d     = 1'b1;
            mem_addr_d  = {req.req_addr[31:2], 2'b00};
            mem_wdata_d = req.req_wdata;
          end
        end
      end
      ST_RD: begin
        state_d    = ST_RD_WAIT;
        mem_addr_d = mem_addr_q;
      end
      ST_RD_WAIT: begin
        if (!we_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = rdata_ext;
          resp_mis_d   = 1'b0;
          resp_fault_d = 1'b0;
        end else begin
          state_d     = ST_WR;
          mem_w_d     = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = merged;
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_mis_d   = 1'b0;
        resp_fault_d = 1'b0;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      resp_fault_q <= resp_fault_d;
      mem_r_q      <= mem_r_d;
      mem_w_q      <= mem_w_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req.req_ready       = req_ready_q;
  assign req.resp_valid      = resp_valid_q;
  assign req.resp_rdata      = resp_rdata_q;
  assign req.resp_misaligned = resp_mis_q;
  assign req.resp_fault      = resp_fault_q;
  assign mem.mem_addr        = mem_addr_q;
  assign mem.mem_r_enable    = mem_r_q;
  assign mem.mem_w_enable    = mem_w_q;
  assign mem.mem_wdata       = mem_wdata_q;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store unit: the initiator side of the core's word-wide data-memory port.
- Takes one load or store request at a time from the execute stage and converts byte/halfword/word RV32I accesses into word accesses on the data memory.
- Sub-word stores use read-modify-write, because the memory port has no byte enables.
- Sits between the execute stage and the data memory; returns sign- or zero-extended load data and fault flags to writeback.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; word index >= MEM_WORDS is an access fault.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse, request complete.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_misaligned  output  1  H access with addr[0]=1, or W access with addr[1:0]!=0.
- resp_fault  output  1  illegal funct3 (011/110/111, or 1xx on a store), or word index out of range.
- mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}.
- mem_r_enable  output  1  read strobe.
- mem_w_enable  output  1  write strobe.
- mem_wdata  output  32  full write word.
- mem_rdata  input  32  registered read data, valid the cycle after mem_r_enable.

Behaviour:
- States: IDLE, RD, RD_WAIT, WR, RESP.
- Reset: state=IDLE, all outputs 0 except req_ready=1, internal registers cleared.
- IDLE:
  - req_ready=1; accepts on req_valid. Latches we, funct3, addr, wdata.
  - Checks in priority order: fault, then misaligned, then access kind.
  - Fault or misaligned -> RESP with the flag set; no memory strobe is ever asserted.
  - Load, SB or SH -> RD. SW -> WR with mem_wdata=wdata.
- RD: mem_r_enable=1, mem_addr valid -> RD_WAIT.
- RD_WAIT: mem_rdata sampled.
  - Load: extract byte/half at addr[1:0] (little-endian), extend per funct3, register into resp_rdata, -> RESP.
  - SB/SH: merge wdata[7:0] or wdata[15:0] into the read word at byte offset addr[1:0], register the merged word, -> WR.
- WR: mem_w_enable=1, mem_wdata = merged word (or full wdata for SW) -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_* registers hold their values until the next response.
- mem_r_enable and mem_w_enable are never asserted in the same cycle. Each is high for exactly one cycle per access.
- mem_addr is held at the latched aligned address from RD through WR; 0 in IDLE.
- Latency from accept cycle N to resp_valid:
  - Fault or misaligned: N+1.
  - SW: N+2.
  - Load: N+3.
  - SB/SH: N+4.
- req_ready=0 outside IDLE. req_valid in those cycles is ignored; the requester holds it until req_ready=1.
- Reset asserted mid-operation: immediate return to IDLE, strobes drop to 0 asynchronously. A pending RMW write is discarded; the memory word keeps its old value.
- Boundary: word index MEM_WORDS-1 is legal; index MEM_WORDS is a fault. addr[31:2] is compared as unsigned.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum lsu_state_t.
- One combinational sub-module, lsu_align, implements load extract/extend and store merge. Inputs: offset[1:0], funct3, word, wdata. Outputs: rdata_ext and merged.

Test Plan:
- Load, signed byte: preload word 0x19C = 0xFF0F0E0D; LB addr 0x19F -> resp_rdata 0xFFFFFFFF at N+3. LBU at the same address -> 0x000000FF. LB addr 0x19C -> 0x0000000D.
- Load, signed half: LH addr 0x19E -> 0xFFFFFF0F. LHU addr 0x19E -> 0x0000FF0F. LW addr 0x19C -> 0xFF0F0E0D, with exactly one mem_r_enable pulse.
- Byte store RMW: preload word 0x100 = 0x11223344; SB addr 0x101, wdata 0xDEADBEAB. Expect mem_r_enable at N+1, mem_w_enable at N+3 with mem_wdata 0x1122AB44, resp_valid at N+4.
- Half and word stores: SH addr 0x102, wdata 0x5566 -> word becomes 0x55663344. SW addr 0x104, wdata 0xCAFEBABE -> no read strobe, write at N+1, resp at N+2.
- Faults: LH addr 0x101 -> resp_misaligned=1 at N+1. SW addr 0x102 -> resp_misaligned=1. funct3=011 -> resp_fault=1. LW addr 0x400 (index 256) -> resp_fault=1. In all four cases no strobe is asserted.
- Reset mid-RMW: assert rst in the RD_WAIT cycle of SB 0x100 -> no mem_w_enable ever; after release req_ready=1 and word 0x100 is unchanged.
